banked_multiport_ram: RTL and testbench

Parametrised single-clock multiport RAM: P_NUM_WR write ports and P_NUM_RD read ports share P_NUM_BANK single-port banks, interleaved on the low address bits. Each bank serves at most one access per cycle. Same-bank contention is resolved by a per-bank round-robin arbiter, and losers are back-pressured through valid/ready. It is the scalable replacement for the fixed 2R2W register/scratch memory in the VP datapath, and needs no multipumping clock.

---
 rtl/banked_multiport_ram.sv | 99 +++++++++
 tb/tb_banked_multiport_ram.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_multiport_ram.sv
// banked_multiport_ram: multiport RAM built from single-port banks interleaved on the low
// address bits, with a round-robin arbiter per bank and valid/ready back-pressure.
module banked_multiport_ram #(
    parameter int P_MEM_DEPTH = 2048,
    parameter int P_MEM_WIDTH = 32,
    parameter int P_NUM_WR    = 2,
    parameter int P_NUM_RD    = 2,
    parameter int P_NUM_BANK  = 4
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [P_NUM_WR-1:0]                            wr_valid_i,
    input  logic [P_NUM_WR*$clog2(P_MEM_DEPTH)-1:0]        wr_addr_i,
    input  logic [P_NUM_WR*P_MEM_WIDTH-1:0]                wr_data_i,
    output logic [P_NUM_WR-1:0]                            wr_ready_o,
    input  logic [P_NUM_RD-1:0]                            rd_valid_i,
    input  logic [P_NUM_RD*$clog2(P_MEM_DEPTH)-1:0]        rd_addr_i,
    output logic [P_NUM_RD-1:0]                            rd_ready_o,
    output logic [P_NUM_RD*P_MEM_WIDTH-1:0]                rd_data_o,
    output logic [P_NUM_RD-1:0]                            rd_rvalid_o
);
    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);
    localparam int LP_BANK_BITS   = $clog2(P_NUM_BANK);
    localparam int LP_NUM_REQ     = P_NUM_WR + P_NUM_RD;
    localparam int BANK_W         = LP_BANK_BITS > 0 ? LP_BANK_BITS : 1;
    localparam int ROWS           = P_MEM_DEPTH / P_NUM_BANK;
    localparam int ROW_W          = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int REQ_W          = $clog2(LP_NUM_REQ) > 0 ? $clog2(LP_NUM_REQ) : 1;

    logic [LP_NUM_REQ-1:0]  req_valid;
    logic [BANK_W-1:0]      req_bank [LP_NUM_REQ];
    logic [ROW_W-1:0]       req_row  [LP_NUM_REQ];
    logic [P_MEM_WIDTH-1:0] wdata    [P_NUM_WR];
    logic [LP_NUM_REQ-1:0]  grant;
    logic [REQ_W-1:0]       ptr       [P_NUM_BANK];
    logic                   bank_gnt  [P_NUM_BANK];
    logic [REQ_W-1:0]       bank_sel  [P_NUM_BANK];
    logic                   bank_we   [P_NUM_BANK];
    logic [ROW_W-1:0]       bank_row  [P_NUM_BANK];
    logic [P_MEM_WIDTH-1:0] bank_wdata[P_NUM_BANK];
    logic [P_MEM_WIDTH-1:0] mem [P_NUM_BANK][ROWS];

    // Requesters are writes first, then reads; modulo/divide keeps P_NUM_BANK=1 legal.
    always_comb begin
        for (int w = 0; w < P_NUM_WR; w++) begin
            req_valid[w] = wr_valid_i[w];
            req_bank[w]  = BANK_W'(wr_addr_i[w*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] % P_NUM_BANK);
            req_row[w]   = ROW_W'(wr_addr_i[w*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] / P_NUM_BANK);
            wdata[w]     = wr_data_i[w*P_MEM_WIDTH +: P_MEM_WIDTH];
        end
        for (int k = 0; k < P_NUM_RD; k++) begin
            req_valid[P_NUM_WR+k] = rd_valid_i[k];
            req_bank[P_NUM_WR+k]  = BANK_W'(rd_addr_i[k*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] % P_NUM_BANK);
            req_row[P_NUM_WR+k]   = ROW_W'(rd_addr_i[k*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] / P_NUM_BANK);
        end
    end

    always_comb begin
        grant = '0;
        for (int b = 0; b < P_NUM_BANK; b++) begin
            bank_gnt[b] = 1'b0;
            bank_sel[b] = '0;
            for (int i = 0; i < LP_NUM_REQ; i++) begin
                int idx;
                idx = (int'(ptr[b]) + i) % LP_NUM_REQ;
                if (!bank_gnt[b] && req_valid[idx] && req_bank[idx] == BANK_W'(b)) begin
                    bank_gnt[b] = 1'b1;
                    bank_sel[b] = REQ_W'(idx);
                end
            end
            if (bank_gnt[b]) grant[bank_sel[b]] = 1'b1;
            bank_row[b]   = req_row[bank_sel[b]];
            bank_we[b]    = bank_gnt[b] && rst_ni && int'(bank_sel[b]) < P_NUM_WR;
            bank_wdata[b] = int'(bank_sel[b]) < P_NUM_WR ? wdata[bank_sel[b]] : '0;
        end
        wr_ready_o = grant[P_NUM_WR-1:0] & {P_NUM_WR{rst_ni}};
        rd_ready_o = grant[LP_NUM_REQ-1:P_NUM_WR] & {P_NUM_RD{rst_ni}};
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < P_NUM_BANK; b++)
            if (bank_we[b]) mem[b][bank_row[b]] <= bank_wdata[b];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o   <= '0;
            rd_rvalid_o <= '0;
            for (int b = 0; b < P_NUM_BANK; b++) ptr[b] <= '0;
        end else begin
            rd_rvalid_o <= rd_ready_o;
            for (int k = 0; k < P_NUM_RD; k++)
                if (rd_ready_o[k])
                    rd_data_o[k*P_MEM_WIDTH +: P_MEM_WIDTH] <= mem[req_bank[P_NUM_WR+k]][req_row[P_NUM_WR+k]];
            for (int b = 0; b < P_NUM_BANK; b++)
                if (bank_gnt[b]) ptr[b] <= REQ_W'((int'(bank_sel[b]) + 1) % LP_NUM_REQ);
        end
    end
endmodule

// File: tb/tb_banked_multiport_ram.sv
// tb_banked_multiport_ram: directed self-checking bench for banked_multiport_ram at default
// parameters (4 banks, 2 write ports, 2 read ports, 11-bit addresses, 32-bit words).
module tb_banked_multiport_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wr_valid = '0;
    logic [21:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [1:0]  wr_ready;
    logic [1:0]  rd_valid = '0;
    logic [21:0] rd_addr = '0;
    logic [1:0]  rd_ready;
    logic [63:0] rd_data;
    logic [1:0]  rd_rvalid;
    int checks = 0;
    int fails = 0;

    banked_multiport_ram dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
        .rd_data_o(rd_data), .rd_rvalid_o(rd_rvalid)
    );

    always #5 clk = ~clk;

    task automatic set_wr(input int p, input logic v, input logic [10:0] a, input logic [31:0] d);
        wr_valid[p] = v;
        wr_addr[p*11 +: 11] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input int p, input logic v, input logic [10:0] a);
        rd_valid[p] = v;
        rd_addr[p*11 +: 11] = a;
    endtask

    task automatic idle();
        wr_valid = '0;
        rd_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk) set_wr(0, 1, 7, 32'h77);
        @(posedge clk);
        @(negedge clk) idle();
        rst_n = 1'b0;
        set_wr(0, 1, 7, 32'hBAD);
        set_rd(0, 1, 7);
        #1;
        checks++; if (wr_ready !== 2'b00) begin fails++; $display("FAIL reset_wr_ready got %b want 00", wr_ready); end
        checks++; if (rd_ready !== 2'b00) begin fails++; $display("FAIL reset_rd_ready got %b want 00", rd_ready); end
        checks++; if (rd_rvalid !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b want 00", rd_rvalid); end
        checks++; if (rd_data !== 64'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        @(posedge clk) #1;
        checks++; if (rd_rvalid !== 2'b00) begin fails++; $display("FAIL reset_rvalid_edge got %b want 00", rd_rvalid); end
        @(negedge clk) idle();
        rst_n = 1'b1;
        @(negedge clk) set_rd(0, 1, 7);
        #1;
        checks++; if (rd_ready !== 2'b01) begin fails++; $display("FAIL reset_nocommit_ready got %b want 01", rd_ready); end
        @(posedge clk) #1;
        checks++; if (rd_data[31:0] !== 32'h77) begin fails++; $display("FAIL reset_nocommit_data got %h want 00000077", rd_data[31:0]); end
        @(negedge clk) idle();
    endtask

    task automatic test_write_read();
        @(negedge clk) set_wr(0, 1, 5, 32'hDEADBEEF);
        #1;
        checks++; if (wr_ready !== 2'b01) begin fails++; $display("FAIL wr_ready got %b want 01", wr_ready); end
        @(posedge clk);
        @(negedge clk) idle();
        set_rd(0, 1, 5);
        #1;
        checks++; if (rd_ready !== 2'b01) begin fails++; $display("FAIL rd_ready got %b want 01", rd_ready); end
        @(posedge clk) #1;
        checks++; if (rd_rvalid !== 2'b01) begin fails++; $display("FAIL rd_rvalid got %b want 01", rd_rvalid); end
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", rd_data[31:0]); end
        @(negedge clk) idle();
        @(posedge clk) #1;
        checks++; if (rd_rvalid !== 2'b00) begin fails++; $display("FAIL rvalid_pulse got %b want 00", rd_rvalid); end
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data_hold got %h want deadbeef", rd_data[31:0]); end
    endtask

    task automatic test_conflict_free();
        @(negedge clk) set_wr(0, 1, 2, 32'h22);
        set_wr(1, 1, 3, 32'h33);
        #1;
        checks++; if (wr_ready !== 2'b11) begin fails++; $display("FAIL cf_pre_ready got %b want 11", wr_ready); end
        @(posedge clk);
        @(negedge clk) set_wr(0, 1, 0, 32'h100);
        set_wr(1, 1, 1, 32'h101);
        set_rd(0, 1, 2);
        set_rd(1, 1, 3);
        #1;
        checks++; if ({rd_ready, wr_ready} !== 4'b1111) begin fails++; $display("FAIL cf_ready got %b want 1111", {rd_ready, wr_ready}); end
        @(posedge clk) #1;
        checks++; if (rd_rvalid !== 2'b11) begin fails++; $display("FAIL cf_rvalid got %b want 11", rd_rvalid); end
        checks++; if (rd_data !== {32'h33, 32'h22}) begin fails++; $display("FAIL cf_data got %h want 0000003300000022", rd_data); end
        @(negedge clk) idle();
    endtask

    task automatic test_conflict();
        do_reset();
        @(negedge clk) set_wr(0, 1, 1, 32'h11);
        set_rd(0, 1, 5);
        #1;
        checks++; if (wr_ready !== 2'b01) begin fails++; $display("FAIL conf_wr_ready got %b want 01", wr_ready); end
        checks++; if (rd_ready !== 2'b00) begin fails++; $display("FAIL conf_rd_ready got %b want 00", rd_ready); end
        @(posedge clk) #1;
        checks++; if (rd_rvalid !== 2'b00) begin fails++; $display("FAIL conf_rvalid0 got %b want 00", rd_rvalid); end
        @(negedge clk) set_wr(0, 0, 1, 32'h11);
        #1;
        checks++; if (rd_ready !== 2'b01) begin fails++; $display("FAIL conf_rd_retry got %b want 01", rd_ready); end
        @(posedge clk) #1;
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL conf_rd_data got %h want deadbeef", rd_data[31:0]); end
        // Pointer of bank 1 is now 3, so with all four requesting bank 1 only rd1 wins.
        @(negedge clk) set_wr(0, 1, 9, 32'h99);
        set_wr(1, 1, 13, 32'hD);
        set_rd(0, 1, 1);
        set_rd(1, 1, 5);
        #1;
        checks++; if ({rd_ready, wr_ready} !== 4'b1000) begin fails++; $display("FAIL conf_ptr got %b want 1000", {rd_ready, wr_ready}); end
        @(posedge clk) #1;
        checks++; if (rd_data[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL conf_rd1_data got %h want deadbeef", rd_data[63:32]); end
        @(negedge clk) idle();
    endtask

    task automatic test_round_robin();
        int cnt [4];
        logic [3:0] want;
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        do_reset();
        @(negedge clk) set_wr(0, 1, 0, 32'hA0);
        set_wr(1, 1, 4, 32'hA4);
        set_rd(0, 1, 8);
        set_rd(1, 1, 12);
        for (int c = 0; c < 8; c++) begin
            #1;
            want = 4'b0001 << (c % 4);
            checks++; if ({rd_ready, wr_ready} !== want) begin fails++; $display("FAIL rr_cycle%0d got %b want %b", c, {rd_ready, wr_ready}, want); end
            for (int p = 0; p < 4; p++) if ({rd_ready, wr_ready}[p] === 1'b1) cnt[p]++;
            @(posedge clk);
            @(negedge clk);
        end
        idle();
        for (int p = 0; p < 4; p++) begin
            checks++; if (cnt[p] != 2) begin fails++; $display("FAIL rr_count_req%0d got %0d want 2", p, cnt[p]); end
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        @(negedge clk) set_wr(0, 1, 8, 32'hA);
        set_wr(1, 1, 8, 32'hB);
        #1;
        checks++; if (wr_ready !== 2'b01) begin fails++; $display("FAIL same_first got %b want 01", wr_ready); end
        @(posedge clk);
        @(negedge clk) set_wr(0, 0, 8, 32'hA);
        #1;
        checks++; if (wr_ready !== 2'b10) begin fails++; $display("FAIL same_second got %b want 10", wr_ready); end
        @(posedge clk);
        @(negedge clk) idle();
        set_rd(0, 1, 8);
        #1;
        checks++; if (rd_ready !== 2'b01) begin fails++; $display("FAIL same_rd_ready got %b want 01", rd_ready); end
        @(posedge clk) #1;
        checks++; if (rd_data[31:0] !== 32'hB) begin fails++; $display("FAIL same_rd_data got %h want 0000000b", rd_data[31:0]); end
        @(negedge clk) idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk) set_wr(0, 1, 16, 32'h1600);
        set_wr(1, 1, 17, 32'h1700);
        @(posedge clk);
        @(negedge clk) set_wr(0, 1, 18, 32'h1800);
        set_wr(1, 1, 19, 32'h1900);
        @(posedge clk);
        @(negedge clk) idle();
        for (int i = 0; i < 4; i++) begin
            set_rd(0, 1, 11'(16 + i));
            #1;
            checks++; if (rd_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got %b want 1", i, rd_ready[0]); end
            @(posedge clk) #1;
            checks++; if (rd_rvalid[0] !== 1'b1 || rd_data[31:0] !== 32'h1600 + 32'(i) * 32'h100)
                begin fails++; $display("FAIL b2b_data%0d got %b/%h want 1/%h", i, rd_rvalid[0], rd_data[31:0], 32'h1600 + 32'(i) * 32'h100); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk) set_wr(1, 1, 3, 32'h3333);
        @(posedge clk);
        @(negedge clk) idle();
        set_rd(1, 1, 3);
        #1;
        checks++; if (rd_ready !== 2'b10) begin fails++; $display("FAIL mid_ready got %b want 10", rd_ready); end
        @(posedge clk) #1;
        checks++; if (rd_rvalid !== 2'b10) begin fails++; $display("FAIL mid_rvalid_pre got %b want 10", rd_rvalid); end
        #2 rst_n = 1'b0;
        idle();
        #1;
        checks++; if (rd_rvalid !== 2'b00) begin fails++; $display("FAIL mid_rvalid_async got %b want 00", rd_rvalid); end
        checks++; if (rd_data !== 64'h0) begin fails++; $display("FAIL mid_data_async got %h want 0", rd_data); end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        checks++; if (rd_rvalid !== 2'b00) begin fails++; $display("FAIL mid_rvalid_post got %b want 00", rd_rvalid); end
        @(negedge clk) set_rd(1, 1, 3);
        #1;
        checks++; if (rd_ready !== 2'b10) begin fails++; $display("FAIL mid_reread_ready got %b want 10", rd_ready); end
        @(posedge clk) #1;
        checks++; if (rd_data[63:32] !== 32'h3333) begin fails++; $display("FAIL mid_reread_data got %h want 00003333", rd_data[63:32]); end
        @(negedge clk) idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict_free();
        test_conflict();
        test_round_robin();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
